sprite_row_fetcher: RTL and testbench
=====================================

// Module: sprite_row_fetcher
// PURPOSE
//  Read-side master for the 256x16 sprite ROM blocks: fetches one 64-pixel, 1bpp sprite row
//  (4 words) per request, with a vertical scroll offset for reel animation.
//  Captures ROM data with configurable read latency (0 = combinational ROM, 1 = registered ROM).
//  Presents the completed row in a display buffer for per-pixel lookup by the video/reel renderer.
// PARAMETERS
//  ROM_LATENCY    1   cycles from rom_addr to valid rom_dout; legal values 0 and 1
//  DATA_WIDTH     16  ROM word width (pixels per word)
//  ADDRESS_WIDTH  8   ROM address width
//  WORDS_PER_ROW  4   words per sprite row (64 pixels)
//  ROW_BITS       6   log2 of rows per sprite (64)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   row fetch request
//  req_ready   out  1   high when IDLE; request accepted on req_valid && req_ready
//  req_row     in   6   sprite row requested
//  req_offset  in   6   scroll offset added to req_row
//  rom_addr    out  8   ROM address
//  rom_dout    in   16  ROM read data
//  line_done   out  1   1-cycle pulse: disp_buf now holds the newly fetched row
//  pix_x       in   6   pixel column select, 0 = leftmost
//  pix_out     out  1   pixel of displayed row at pix_x (combinational from disp_buf)
// BEHAVIOUR
//  Reset: state IDLE; rom_addr=0; fill_buf=0; disp_buf=0 (pix_out=0); line_done=0; req_ready=1.
//  Reset mid-fetch aborts: partial fill discarded, disp_buf cleared, no line_done.
//  Row arithmetic: eff_row = (req_row + req_offset) mod 64 (6-bit wrap, carry dropped).
//   req_row, req_offset and eff_row are latched at acceptance; later changes are ignored.
//  Addressing: word k (0..3) at rom_addr = {eff_row, k[1:0]}.
//  FSM IDLE -> FETCH -> COMMIT -> IDLE.
//   IDLE: req_ready=1. Acceptance in cycle T -> FETCH at T+1.
//    req_valid while not IDLE is ignored, not queued.
//   FETCH: rom_addr (registered) = word k during cycle T+1+k, k=0..3.
//    Word k is sampled at the end of cycle T+1+k+ROM_LATENCY.
//    Issue and capture counters run independently, so word k+1 issue overlaps word k capture.
//    After the word 3 capture -> COMMIT.
//   COMMIT: one cycle; disp_buf <= fill_buf at the end of the cycle -> IDLE.
//   Next IDLE cycle (T+6+ROM_LATENCY): line_done=1, req_ready=1, new row visible on pix_out.
//    A request accepted in that same cycle starts immediately.
//   IDLE: rom_addr holds its last value.
//  Packing: disp_buf[63:0] = {w0,w1,w2,w3}, MSB first; pix_out = disp_buf[63 - pix_x].
//  disp_buf changes only at COMMIT, so pix_out is stable during a fetch (double-buffered).
//  Back-to-back throughput: one row per 6+ROM_LATENCY cycles.
// TESTING
//  Bench ROM model supports latency 0 and 1; run all scenarios at both latencies.
//  1 Reset, then req_row=0, offset=0, ROM word n = n:
//    rom_addr 0,1,2,3 on consecutive cycles;
//    line_done exactly at T+6+L;
//    disp_buf = 0x0000_0001_0002_0003; pix_out(63)=1, pix_out(0)=0.
//  2 Wrap: req_row=60, offset=7 -> eff_row=3; rom_addr 0x0C..0x0F.
//  3 Busy request: req_valid held high through a fetch -> second fetch starts the cycle line_done
//    is high, not earlier; req_row change mid-fetch has no effect on rom_addr.
//  4 Stability: row A displayed, fetch row B with different data -> pix_out shows A
//    until line_done, then B.
//  5 Reset asserted in the second FETCH cycle -> next cycle:
//    req_ready=1, rom_addr=0, pix_out=0 for all x; no line_done pulse.
//  6 Pattern word 0x8001 in all 4 words -> pix_out=1 at x=0,15,16,31,32,47,48,63;
//    0 at all other x.

Source files
------------

// File: rtl/sprite_row_fetcher.sv
// Fetches one multi-word 1bpp sprite row from ROM into a fill buffer, then commits it to a
// display buffer that drives per-pixel lookup. Supports combinational or registered ROMs.
module sprite_row_fetcher #(
    parameter int unsigned ROM_LATENCY   = 1,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned WORDS_PER_ROW = 4,
    parameter int unsigned ROW_BITS      = 6,
    localparam int unsigned RowPixels    = DATA_WIDTH * WORDS_PER_ROW,
    localparam int unsigned PixBits      = $clog2(RowPixels),
    localparam int unsigned WordBits     = $clog2(WORDS_PER_ROW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ROW_BITS-1:0]      req_row,
    input  logic [ROW_BITS-1:0]      req_offset,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic                     line_done,
    input  logic [PixBits-1:0]       pix_x,
    output logic                     pix_out
);

    localparam logic [WordBits-1:0] LastWord = WordBits'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StCommit} state_e;

    state_e                     state_q, state_d;
    logic [ROW_BITS-1:0]        eff_row_q, eff_row_d;
    logic [ADDRESS_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                       iss_active_q, iss_active_d;
    logic [WordBits-1:0]        iss_cnt_q, iss_cnt_d;
    logic [WordBits-1:0]        cap_cnt_q, cap_cnt_d;
    logic [RowPixels-1:0]       fill_buf_q, fill_buf_d;
    logic [RowPixels-1:0]       disp_buf_q, disp_buf_d;
    logic                       line_done_q, line_done_d;
    logic                       cap_valid;
    logic [ROW_BITS-1:0]        eff_row_sum;
    logic [PixBits-1:0]         pix_idx;

    assign eff_row_sum = req_row + req_offset;

    // Capture trails issue by the ROM latency; the issue strobe is simply delayed to match.
    if (ROM_LATENCY == 0) begin : g_lat0
        assign cap_valid = iss_active_q;
    end else begin : g_lat1
        logic iss_dly_q;
        always_ff @(posedge clk) begin
            if (reset) iss_dly_q <= 1'b0;
            else       iss_dly_q <= iss_active_q;
        end
        assign cap_valid = iss_dly_q;
    end

    always_comb begin
        state_d      = state_q;
        eff_row_d    = eff_row_q;
        rom_addr_d   = rom_addr_q;
        iss_active_d = iss_active_q;
        iss_cnt_d    = iss_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        fill_buf_d   = fill_buf_q;
        disp_buf_d   = disp_buf_q;
        line_done_d  = 1'b0;
        req_ready    = (state_q == StIdle);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d      = StFetch;
                    eff_row_d    = eff_row_sum;
                    rom_addr_d   = {eff_row_sum, {WordBits{1'b0}}};
                    iss_active_d = 1'b1;
                    iss_cnt_d    = '0;
                    cap_cnt_d    = '0;
                end
            end
            StFetch: begin
                if (iss_active_q) begin
                    if (iss_cnt_q == LastWord) begin
                        iss_active_d = 1'b0;
                    end else begin
                        iss_cnt_d  = iss_cnt_q + WordBits'(1);
                        rom_addr_d = {eff_row_q, iss_cnt_q + WordBits'(1)};
                    end
                end
                if (cap_valid) begin
                    // Shift words in from the right so word 0 ends up in the MSBs.
                    fill_buf_d = {fill_buf_q[RowPixels-DATA_WIDTH-1:0], rom_dout};
                    cap_cnt_d  = cap_cnt_q + WordBits'(1);
                    if (cap_cnt_q == LastWord) state_d = StCommit;
                end
            end
            StCommit: begin
                disp_buf_d  = fill_buf_q;
                line_done_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            eff_row_q    <= '0;
            rom_addr_q   <= '0;
            iss_active_q <= 1'b0;
            iss_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            fill_buf_q   <= '0;
            disp_buf_q   <= '0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            eff_row_q    <= eff_row_d;
            rom_addr_q   <= rom_addr_d;
            iss_active_q <= iss_active_d;
            iss_cnt_q    <= iss_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            fill_buf_q   <= fill_buf_d;
            disp_buf_q   <= disp_buf_d;
            line_done_q  <= line_done_d;
        end
    end

    assign pix_idx   = PixBits'(RowPixels - 1) - pix_x;
    assign pix_out   = disp_buf_q[pix_idx];
    assign rom_addr  = rom_addr_q;
    assign line_done = line_done_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Runs two fetchers (ROM latency 0 and 1) on shared stimulus against a timestamp-based
// reference model, plus directed row, wrap, busy, stability, reset and pattern scenarios.
module tb_sprite_row_fetcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [5:0] req_row = '0;
    logic [5:0] req_offset = '0;
    logic [5:0] pix_x = '0;

    logic [1:0]  ready_v;
    logic [1:0]  done_v;
    logic [1:0]  pix_v;
    logic [7:0]  addr_v [2];
    logic [15:0] dout_v [2];
    logic [15:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state, one slot per ROM latency.
    bit          m_busy [2];
    int          m_t    [2];
    logic [5:0]  m_eff  [2];
    logic [63:0] m_disp [2];
    logic [7:0]  m_hold [2];
    int          m_done [2];

    always #100 clk = ~clk;

    assign dout_v[0] = rom[addr_v[0]];
    always @(posedge clk) dout_v[1] <= rom[addr_v[1]];

    sprite_row_fetcher #(.ROM_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_v[0]),
        .req_row(req_row), .req_offset(req_offset), .rom_addr(addr_v[0]),
        .rom_dout(dout_v[0]), .line_done(done_v[0]), .pix_x(pix_x), .pix_out(pix_v[0])
    );

    sprite_row_fetcher #(.ROM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_v[1]),
        .req_row(req_row), .req_offset(req_offset), .rom_addr(addr_v[1]),
        .rom_dout(dout_v[1]), .line_done(done_v[1]), .pix_x(pix_x), .pix_out(pix_v[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_addr(input int l);
        int d;
        int k;
        if (!m_busy[l]) return m_hold[l];
        d = cyc - m_t[l];
        k = (d - 1 > 3) ? 3 : d - 1;
        return {m_eff[l], 2'(k)};
    endfunction

    task automatic model_update(input int l);
        if (reset) begin
            m_busy[l] = 1'b0;
            m_hold[l] = '0;
            m_disp[l] = '0;
            m_done[l] = -1;
        end else if (!m_busy[l] && req_valid) begin
            m_busy[l] = 1'b1;
            m_t[l]    = cyc;
            m_eff[l]  = req_row + req_offset;
        end else if (m_busy[l] && cyc == m_t[l] + 5 + l) begin
            m_disp[l] = {rom[{m_eff[l], 2'd0}], rom[{m_eff[l], 2'd1}],
                         rom[{m_eff[l], 2'd2}], rom[{m_eff[l], 2'd3}]};
            m_busy[l] = 1'b0;
            m_hold[l] = {m_eff[l], 2'd3};
            m_done[l] = cyc + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int l = 0; l < 2; l++) model_update(l);
        cyc++;
        @(negedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            check_eq($sformatf("L%0d req_ready", l), 64'(ready_v[l]), 64'(!m_busy[l]));
            check_eq($sformatf("L%0d line_done", l), 64'(done_v[l]), 64'(m_done[l] == cyc));
            check_eq($sformatf("L%0d rom_addr", l), 64'(addr_v[l]), 64'(exp_addr(l)));
            check_eq($sformatf("L%0d pix_out", l), 64'(pix_v[l]), 64'(m_disp[l][63 - pix_x]));
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && ready_v != 2'b11; i++) step();
        check_eq("idle_timeout", 64'(ready_v), 64'(2'b11));
    endtask

    task automatic fetch(input logic [5:0] row, input logic [5:0] off);
        req_valid  = 1'b1;
        req_row    = row;
        req_offset = off;
        step();
        req_valid = 1'b0;
    endtask

    task automatic scan(input string tag, input logic [63:0] row);
        for (int x = 0; x < 64; x++) begin
            pix_x = 6'(x);
            #1;
            for (int l = 0; l < 2; l++) check_eq(tag, 64'(pix_v[l]), 64'(row[63 - x]));
        end
    endtask

    initial begin
        int t0;
        int rec [2];
        for (int n = 0; n < 256; n++) rom[n] = 16'(n);
        for (int l = 0; l < 2; l++) begin
            m_busy[l] = 1'b0; m_t[l] = 0; m_eff[l] = '0;
            m_disp[l] = '0;   m_hold[l] = '0; m_done[l] = -1;
        end

        // Reset state
        step();
        step();
        reset = 1'b0;
        step();
        for (int l = 0; l < 2; l++) begin
            check_eq("rst_ready", 64'(ready_v[l]), 64'd1);
            check_eq("rst_addr", 64'(addr_v[l]), 64'd0);
            check_eq("rst_done", 64'(done_v[l]), 64'd0);
        end
        scan("rst_pix", 64'd0);

        // Row 0, word n = n: address sequence, completion latency, packing
        t0 = cyc;
        fetch(6'd0, 6'd0);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 2; l++) check_eq("s1_addr", 64'(addr_v[l]), 64'(k));
            step();
        end
        rec[0] = -1;
        rec[1] = -1;
        for (int i = 0; i < 20 && (rec[0] < 0 || rec[1] < 0); i++) begin
            for (int l = 0; l < 2; l++) if (done_v[l] && rec[l] < 0) rec[l] = cyc;
            if (rec[0] < 0 || rec[1] < 0) step();
        end
        check_eq("s1_lat0_done", 64'(rec[0] - t0), 64'd6);
        check_eq("s1_lat1_done", 64'(rec[1] - t0), 64'd7);
        scan("s1_row", 64'h0000_0001_0002_0003);

        // Wrap: 60 + 7 -> row 3
        wait_idle();
        fetch(6'd60, 6'd7);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 2; l++) check_eq("s2_addr", 64'(addr_v[l]), 64'(8'h0C + k));
            step();
        end
        wait_idle();
        scan("s2_row", 64'h000C_000D_000E_000F);

        // Busy request held high; row changes mid-fetch
        req_valid = 1'b1;
        req_row   = 6'd5;
        req_offset = 6'd0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) req_row = 6'd9;
            step();
        end
        req_valid = 1'b0;
        wait_idle();

        // Stability: A displayed, B fetched with different data
        for (int n = 0; n < 256; n++) rom[n] = 16'($urandom);
        fetch(6'd10, 6'd0);
        wait_idle();
        fetch(6'd20, 6'd0);
        for (int i = 0; i < 12; i++) begin
            pix_x = 6'($urandom_range(63));
            step();
        end
        wait_idle();

        // Reset in the second fetch cycle
        for (int n = 0; n < 256; n++) rom[n] = 16'hFFFF;
        fetch(6'd33, 6'd0);
        wait_idle();
        fetch(6'd34, 6'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            check_eq("s5_ready", 64'(ready_v[l]), 64'd1);
            check_eq("s5_addr", 64'(addr_v[l]), 64'd0);
            check_eq("s5_done", 64'(done_v[l]), 64'd0);
        end
        scan("s5_pix", 64'd0);
        for (int i = 0; i < 10; i++) step();

        // Pattern 0x8001 in every word
        for (int n = 0; n < 256; n++) rom[n] = 16'h8001;
        fetch(6'd17, 6'd40);
        wait_idle();
        scan("s6_pix", 64'h8001_8001_8001_8001);

        // Randomized traffic
        for (int n = 0; n < 256; n++) rom[n] = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            req_valid  = ($urandom_range(3) != 0);
            req_row    = 6'($urandom_range(63));
            req_offset = 6'($urandom_range(63));
            pix_x      = 6'($urandom_range(63));
            reset      = ($urandom_range(59) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
